// File: rtl/acc4_pkg.sv
// Shared types and constants for the acc4 accumulator stage.
package acc4_pkg;

  localparam int unsigned ACC4_WIDTH = 4;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_CLR  = 2'b11
  } op_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RESULT = 1'b1
  } state_t;

endpackage

// File: rtl/acc4_alu.sv
// Combinational next-accumulator logic for acc4_stage.
// Define ACC4_STAGE_SAT_EN for saturating ADD/SUB instead of wrap-around.
module acc4_alu
  import acc4_pkg::*;
#(
  parameter int unsigned WIDTH = ACC4_WIDTH
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] nxt_acc,
  output logic             nxt_carry,
  output logic             nxt_zero
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  // The extra MSB holds the ADD carry-out or, for SUB, the borrow (in_data > acc).
  assign sum  = {1'b0, acc} + {1'b0, in_data};
  assign diff = {1'b0, acc} - {1'b0, in_data};

  always_comb begin
    nxt_acc   = '0;
    nxt_carry = 1'b0;
    case (op_t'(op))
      OP_LOAD: nxt_acc = in_data;
      OP_ADD: begin
        nxt_carry = sum[WIDTH];
`ifdef ACC4_STAGE_SAT_EN
        nxt_acc = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
        nxt_acc = sum[WIDTH-1:0];
`endif
      end
      OP_SUB: begin
        nxt_carry = diff[WIDTH];
`ifdef ACC4_STAGE_SAT_EN
        nxt_acc = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
`else
        nxt_acc = diff[WIDTH-1:0];
`endif
      end
      OP_CLR: ;
    endcase
  end

  assign nxt_zero = (nxt_acc == '0);

endmodule

// File: rtl/acc4_stage.sv
// Registered accumulator stage with valid/ready handshake on both sides.
// Optional saturating arithmetic via ACC4_STAGE_SAT_EN (handled in acc4_alu).
module acc4_stage
  import acc4_pkg::*;
#(
  parameter int unsigned WIDTH = ACC4_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             carry,
  output logic             zero
);

  state_t           state, state_nxt;
  logic             accept;
  logic [WIDTH-1:0] alu_acc;
  logic             alu_carry;
  logic             alu_zero;

  acc4_alu #(.WIDTH(WIDTH)) u_alu (
    .acc       (out_data),
    .in_data   (in_data),
    .op        (op),
    .nxt_acc   (alu_acc),
    .nxt_carry (alu_carry),
    .nxt_zero  (alu_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b1;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        accept = in_valid;
        if (accept) state_nxt = ST_RESULT;
      end
      ST_RESULT: begin
        // out_ready feeds straight through so a consumed result frees the slot this cycle.
        out_valid = 1'b1;
        in_ready  = out_ready;
        accept    = in_valid && out_ready;
        if (out_ready && !in_valid) state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      carry    <= 1'b0;
      zero     <= 1'b1;
    end else if (accept) begin
      out_data <= alu_acc;
      carry    <= alu_carry;
      zero     <= alu_zero;
    end
  end

endmodule

// File: tb/tb_acc4_stage.sv
// Scoreboard bench for acc4_stage: directed cases plus randomized traffic.
module tb_acc4_stage;
  import acc4_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [1:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       carry;
  logic       zero;

  acc4_stage #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .carry     (carry),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int data;
    int cy;
    int zf;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: accumulator, flag, and whether a result is pending.
  int   m_acc   = 0;
  int   m_carry = 0;
  bit   m_valid = 0;

`ifdef ACC4_STAGE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_apply(input int d, input int o);
    int s;
    case (o)
      0: begin m_acc = d; m_carry = 0; end
      1: begin
        s = m_acc + d;
        m_carry = (s > 15) ? 1 : 0;
        if (s > 15) m_acc = SAT ? 15 : s - 16;
        else        m_acc = s;
      end
      2: begin
        m_carry = (d > m_acc) ? 1 : 0;
        if (d > m_acc) m_acc = SAT ? 0 : m_acc - d + 16;
        else           m_acc = m_acc - d;
      end
      default: begin m_acc = 0; m_carry = 0; end
    endcase
    q.push_back('{data: m_acc, cy: m_carry, zf: (m_acc == 0) ? 1 : 0});
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic drive(input logic v, input logic [3:0] d, input logic [1:0] o, input logic r);
    bit exp_rdy;
    in_valid  = v;
    in_data   = d;
    op        = o;
    out_ready = r;
    exp_rdy   = !m_valid || r;
    #1;
    chk("in_ready", int'(in_ready), int'(exp_rdy));
    chk("out_valid", int'(out_valid), int'(m_valid));
    @(posedge clk);
    if (v && exp_rdy) begin
      model_apply(int'(d), int'(o));
      m_valid = 1'b1;
    end else if (r) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  // Monitor: pops an expectation whenever a result is handed downstream, and
  // checks that a stalled result does not move.
  bit       hold_prev = 0;
  logic [3:0] prev_data;
  logic       prev_carry, prev_zero;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (hold_prev && out_valid) begin
          chk("hold_data", int'(out_data), int'(prev_data));
          chk("hold_carry", int'(carry), int'(prev_carry));
          chk("hold_zero", int'(zero), int'(prev_zero));
        end
        if (out_valid && out_ready) begin
          chk("sb_nonempty", (q.size() != 0) ? 1 : 0, 1);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk("sb_data", int'(out_data), e.data);
            chk("sb_carry", int'(carry), e.cy);
            chk("sb_zero", int'(zero), e.zf);
          end
        end
        hold_prev  = out_valid && !out_ready;
        prev_data  = out_data;
        prev_carry = carry;
        prev_zero  = zero;
      end else begin
        hold_prev = 0;
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; op = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_carry", int'(carry), 0);
    chk("rst_zero", int'(zero), 1);
    chk("rst_in_ready", int'(in_ready), 1);
    rst_n = 1'b1;

    // LOAD 5
    drive(1, 4'h5, OP_LOAD, 1);
    chk("load5_data", int'(out_data), 5);
    chk("load5_carry", int'(carry), 0);
    chk("load5_zero", int'(zero), 0);
    chk("load5_valid", int'(out_valid), 1);

    // C + 6
    drive(1, 4'hC, OP_LOAD, 1);
    drive(1, 4'h6, OP_ADD, 1);
    chk("add_ovf_data", int'(out_data), SAT ? 15 : 2);
    chk("add_ovf_carry", int'(carry), 1);

    // 3 - 5, then 0 - 0
    drive(1, 4'h3, OP_LOAD, 1);
    drive(1, 4'h5, OP_SUB, 1);
    chk("sub_unf_data", int'(out_data), SAT ? 0 : 14);
    chk("sub_unf_carry", int'(carry), 1);
    chk("sub_unf_zero", int'(zero), SAT ? 1 : 0);
    drive(1, 4'h0, OP_CLR, 1);
    drive(1, 4'h0, OP_SUB, 1);
    chk("sub0_data", int'(out_data), 0);
    chk("sub0_carry", int'(carry), 0);
    chk("sub0_zero", int'(zero), 1);

    // Stall for 3 cycles with new inputs offered, then release.
    drive(1, 4'h7, OP_LOAD, 1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 4'($urandom_range(15)), OP_ADD, 0);
      chk("stall_data", int'(out_data), 7);
    end
    drive(1, 4'h2, OP_ADD, 1);
    chk("unstall_data", int'(out_data), 9);

    // Back-to-back stream.
    drive(1, 4'h1, OP_LOAD, 1);
    chk("b2b_1", int'(out_data), 1);
    drive(1, 4'h1, OP_ADD, 1);
    chk("b2b_2", int'(out_data), 2);
    drive(1, 4'h1, OP_ADD, 1);
    chk("b2b_3", int'(out_data), 3);
    drive(1, 4'h9, OP_CLR, 1);
    chk("b2b_clr", int'(out_data), 0);
    chk("b2b_zero", int'(zero), 1);

    // Asynchronous reset with a result pending.
    drive(1, 4'hA, OP_LOAD, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_out_data", int'(out_data), 0);
    chk("arst_carry", int'(carry), 0);
    chk("arst_zero", int'(zero), 1);
    chk("arst_in_ready", int'(in_ready), 1);
    q.delete();
    m_valid = 1'b0; m_acc = 0; m_carry = 0;
    #1 rst_n = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(99) < 75) ? 1'b1 : 1'b0,
            4'($urandom_range(15)),
            2'($urandom_range(3)),
            ($urandom_range(99) < 70) ? 1'b1 : 1'b0);
    end
    drive(0, 4'h0, OP_LOAD, 1);
    drive(0, 4'h0, OP_LOAD, 1);
    chk("sb_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/acc4_stage.md
# acc4_stage

Registered 4-bit accumulator stage that sits directly downstream of the 2:1 operand mux and consumes its 4-bit output `o` as its data input. Each accepted transaction applies one operation (load, add, subtract, clear) to an internal accumulator. The stage presents the registered result with carry and zero flags to the next stage over a valid/ready handshake.

## Interface
- `WIDTH`, default 4: data and accumulator width; must match the mux data width.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  upstream presents `in_data`/`op`.
- `in_ready`  out  1  stage can accept this cycle.
- `in_data`  in  WIDTH  operand, wired from mux output `o`.
- `op`  in  2  00 LOAD, 01 ADD, 10 SUB, 11 CLR.
- `out_valid`  out  1  result registers hold an unconsumed result.
- `out_ready`  in  1  downstream accepts the result.
- `out_data`  out  WIDTH  accumulator value.
- `carry`  out  1  ADD carry-out or SUB borrow of the last operation.
- `zero`  out  1  high when `out_data` == 0.

## Operation
- FSM states are IDLE and RESULT.
- Input accept occurs on `in_valid && in_ready` at a rising edge.
- IDLE:
  - `in_ready`=1 and `out_valid`=0.
  - On accept: compute, register the result, go to RESULT.
- RESULT:
  - `out_valid`=1.
  - `in_ready` = `out_ready`, combinational, giving a pass-through pipeline register.
  - `out_ready`=1 with accept: update the result and stay in RESULT (back-to-back).
  - `out_ready`=1 without accept: go to IDLE. Accumulator and flags are retained.
  - `out_ready`=0: hold all outputs stable. `in_data`/`op` are ignored.
- Arithmetic uses a WIDTH+1-bit intermediate.
  - LOAD: acc=`in_data`, carry=0.
  - ADD: {carry,acc} = acc + `in_data`. Wraps modulo 2^WIDTH.
  - SUB: acc = acc − `in_data` mod 2^WIDTH; carry=1 if `in_data` > acc.
  - CLR: acc=0, carry=0; `in_data` is ignored.
- `zero` is registered from the next accumulator value.
- The accumulator persists across transactions, so ADD/SUB use the previous result.

## Timing
- Reset values: acc=0, `out_data`=0, `carry`=0, `zero`=1, `out_valid`=0, state IDLE, `in_ready`=1.
- Reset asserted mid-transaction: outputs go to reset values immediately, independent of the clock. The pending result is lost.
- Latency: accept at edge N → `out_valid` and result visible after edge N, i.e. one cycle.
- Throughput is one operation per cycle while `out_ready` stays high.
- No combinational path from `in_data`/`op` to any output. The only combinational path is `out_ready` → `in_ready`.
- `in_valid` while `in_ready`=0: no state change; upstream must hold its inputs.

## Configuration
- Macro: `ACC4_STAGE_SAT_EN`.
- Defined: ADD overflow saturates acc to all-ones (4'hF); SUB underflow saturates to 0. `carry` still reports overflow/borrow.
- Undefined: wrap-around arithmetic as in Operation.
- LOAD/CLR behaviour, handshake, and timing are identical in both builds.

## Structure
- Package `acc4_pkg`:
  - op encodings `OP_LOAD`, `OP_ADD`, `OP_SUB`, `OP_CLR`.
  - state type with `ST_IDLE`, `ST_RESULT`.
  - default width constant, 4.
- Sub-module `acc4_alu`: combinational block taking acc, `in_data`, `op` and producing next acc, carry, and zero. This module holds all `ACC4_STAGE_SAT_EN` logic.
- Top level contains the FSM, handshake, and result registers.

## Test plan
- Reset, then LOAD 4'h5 with `out_ready`=1 → next cycle `out_data`=5, `carry`=0, `zero`=0, `out_valid`=1.
- From acc=4'hC, ADD 4'h6 → wrap build: `out_data`=2, `carry`=1. SAT build: `out_data`=F, `carry`=1.
- From acc=3, SUB 5 → wrap build: `out_data`=E, `carry`=1. SAT build: `out_data`=0, `zero`=1. Then SUB 0 from 0 → `carry`=0.
- `out_ready`=0 for 3 cycles after a result, with `in_valid`=1 and varying `in_data` → `in_ready`=0 and `out_data` stable. Raise `out_ready` → the new op is accepted that edge.
- Back-to-back stream LOAD 1, ADD 1, ADD 1, CLR with `out_ready`=1 → results 1, 2, 3, 0 on consecutive cycles; `zero`=1 on the last.
- Assert `rst_n`=0 mid-cycle while `out_valid`=1 → `out_valid`, `out_data`, `carry` clear before the next edge, `zero`=1, `in_ready`=1.
